or_gate: RTL and testbench

OR_GATE -- requirements
Module: or_gate

---
 rtl/or_gate.sv | 61 ++++++
 tb/tb_or_gate.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/or_gate.sv
`default_nettype none
// ============================================================================
//  Module      : or_gate
//  Description : Bitwise OR of two operands with a registered copy, a rising
//                activity pulse and a saturating count of active cycles.
//
//  Ports
//    clk       in   1       rising-edge clock for all registered state
//    rst       in   1       synchronous active-high reset
//    a         in   WIDTH   operand A
//    b         in   WIDTH   operand B
//    out       out  WIDTH   combinational a | b (no clock or reset involvement)
//    out_q     out  WIDTH   a | b captured on each rising edge
//    out_rise  out  1       one-cycle pulse after |out_q goes 0 -> 1
//    hi_count  out  CNT_W   saturating count of edges with |out_q high
//
//  Revision    : 1.0  initial release
// ============================================================================
module or_gate #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_q,
   output logic             out_rise,
   output logic [CNT_W-1:0] hi_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic w_any_q;   // any bit of the registered result is high
   logic r_any_d;   // w_any_q as seen on the previous edge

   // Purely combinational path: stays valid even with clk/rst left floating.
   assign out     = a | b;
   assign w_any_q = |out_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q    <= '0;
         out_rise <= 1'b0;
         r_any_d  <= 1'b0;
         hi_count <= '0;
      end else begin
         out_q    <= a | b;
         r_any_d  <= w_any_q;
         // r_any_d is cleared by reset, so leaving reset with out_q low
         // cannot fake an edge; a pulse needs a genuine 0 -> 1 on |out_q.
         out_rise <= w_any_q & ~r_any_d;
         if (w_any_q && (hi_count != CNT_MAX)) begin
            hi_count <= hi_count + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_or_gate.sv
`default_nettype none
// ============================================================================
//  Module      : tb_or_gate
//  Description : Self-checking bench for or_gate (scoreboard of expected
//                registered outputs plus directed constant checks).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_or_gate;

   typedef struct packed {
      logic       q;
      logic       rise;
      logic [7:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // ---- main instance: WIDTH=1, CNT_W=8 ----
   logic       rst = 1'b1;
   logic       a = 1'b0, b = 1'b0;
   logic       out, out_q, out_rise;
   logic [7:0] hi_count;

   or_gate #(.WIDTH(1), .CNT_W(8)) u_dut (
      .clk(clk), .rst(rst), .a(a), .b(b),
      .out(out), .out_q(out_q), .out_rise(out_rise), .hi_count(hi_count)
   );

   // ---- saturation instance: CNT_W=2 ----
   logic       rst_s = 1'b1;
   logic       a_s = 1'b0, b_s = 1'b0;
   logic       out_s, out_q_s, out_rise_s;
   logic [1:0] hi_count_s;

   or_gate #(.WIDTH(1), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst_s), .a(a_s), .b(b_s),
      .out(out_s), .out_q(out_q_s), .out_rise(out_rise_s), .hi_count(hi_count_s)
   );

   // ---- wide instance: WIDTH=8 ----
   logic       rst_w = 1'b1;
   logic [7:0] a_w = 8'h00, b_w = 8'h00;
   logic [7:0] out_w, out_q_w;
   logic       out_rise_w;
   logic [7:0] hi_count_w;

   or_gate #(.WIDTH(8), .CNT_W(8)) u_wide (
      .clk(clk), .rst(rst_w), .a(a_w), .b(b_w),
      .out(out_w), .out_q(out_q_w), .out_rise(out_rise_w), .hi_count(hi_count_w)
   );

   // ---- reference model of the main instance, feeding the scoreboard ----
   exp_t sb[$];
   logic m_q = 1'b0, m_rise = 1'b0, m_prev = 1'b0;
   int   m_cnt = 0;

   // Drive one cycle of stimulus (just after a rising edge) and push what the
   // registered outputs must show after the next rising edge.
   task automatic drive(input logic ia, input logic ib, input logic ir);
      exp_t e;
      a = ia; b = ib; rst = ir;
      if (ir) begin
         m_q = 1'b0; m_rise = 1'b0; m_prev = 1'b0; m_cnt = 0;
      end else begin
         m_rise = m_q && !m_prev;
         m_prev = m_q;
         if (m_q && m_cnt < 255) m_cnt = m_cnt + 1;
         m_q = ia | ib;
      end
      e.q = m_q; e.rise = m_rise; e.cnt = m_cnt[7:0];
      sb.push_back(e);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_truth_table;
      logic [1:0] va [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
      logic       vo [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 4; i++) begin
         a = va[i][1]; b = va[i][0];
         #10;
         checks++;
         if (out !== vo[i]) begin
            errors++;
            $display("FAIL truth_table a=%b b=%b: out=%b expected %b", a, b, out, vo[i]);
         end
      end
   endtask

   task automatic test_reset;
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b0, 1'b1);
         #1;
         checks++;
         if (out !== 1'b1) begin
            errors++;
            $display("FAIL reset_comb cyc%0d: out=%b expected 1", i, out);
         end
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if ({out_q, out_rise, hi_count} !== {e.q, e.rise, e.cnt} || e.q !== 1'b0) begin
            errors++;
            $display("FAIL reset_state cyc%0d: q=%b rise=%b cnt=%0d expected 0 0 0",
                     i, out_q, out_rise, hi_count);
         end
      end
   endtask

   task automatic test_registered;
      exp_t e;
      logic exp_rise [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      drive(1'b0, 1'b0, 1'b1); tick(); void'(sb.pop_front());
      drive(1'b0, 1'b0, 1'b1); tick(); void'(sb.pop_front());
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 1'b0);
         tick();
         e = sb.pop_front();
         checks++;
         if (out_q !== 1'b1 || out_q !== e.q) begin
            errors++;
            $display("FAIL reg_out_q cyc%0d: out_q=%b expected 1", i, out_q);
         end
         checks++;
         if (out_rise !== exp_rise[i] || out_rise !== e.rise) begin
            errors++;
            $display("FAIL reg_out_rise cyc%0d: out_rise=%b expected %b", i, out_rise, exp_rise[i]);
         end
      end
   endtask

   task automatic test_counter;
      exp_t e;
      drive(1'b0, 1'b0, 1'b1); tick(); void'(sb.pop_front());
      for (int i = 0; i < 9; i++) begin
         if (i < 5) drive(1'b1, 1'b0, 1'b0);
         else       drive(1'b0, 1'b0, 1'b0);
         tick();
         e = sb.pop_front();
         checks++;
         if ({out_q, out_rise, hi_count} !== {e.q, e.rise, e.cnt}) begin
            errors++;
            $display("FAIL counter cyc%0d: q=%b rise=%b cnt=%0d expected %b %b %0d",
                     i, out_q, out_rise, hi_count, e.q, e.rise, e.cnt);
         end
      end
      checks++;
      if (hi_count !== 8'd5) begin
         errors++;
         $display("FAIL counter_hold: hi_count=%0d expected 5", hi_count);
      end
   endtask

   task automatic test_mid_reset;
      exp_t e;
      drive(1'b0, 1'b0, 1'b1); tick(); void'(sb.pop_front());
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 1'b0); tick(); void'(sb.pop_front());
      end
      checks++;
      if (hi_count !== 8'd3) begin
         errors++;
         $display("FAIL mid_reset_pre: hi_count=%0d expected 3", hi_count);
      end
      drive(1'b0, 1'b1, 1'b1);
      #1;
      checks++;
      if (out !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_comb: out=%b expected 1", out);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({out_q, out_rise, hi_count} !== 10'b0 || e.cnt !== 8'd0) begin
         errors++;
         $display("FAIL mid_reset_state: q=%b rise=%b cnt=%0d expected 0 0 0",
                  out_q, out_rise, hi_count);
      end
      // Leaving reset with out_q low and inputs low must not pulse out_rise.
      drive(1'b0, 1'b0, 1'b0); tick(); e = sb.pop_front();
      drive(1'b0, 1'b0, 1'b0); tick(); e = sb.pop_front();
      checks++;
      if (out_rise !== 1'b0 || out_rise !== e.rise) begin
         errors++;
         $display("FAIL reset_release_rise: out_rise=%b expected 0", out_rise);
      end
   endtask

   task automatic test_saturation;
      rst_s = 1'b1; tick();
      rst_s = 1'b0; a_s = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      checks++;
      if (hi_count_s !== 2'd3) begin
         errors++;
         $display("FAIL saturate: hi_count=%0d expected 3", hi_count_s);
      end
      tick(); tick();
      checks++;
      if (hi_count_s !== 2'd3) begin
         errors++;
         $display("FAIL saturate_hold: hi_count=%0d expected 3", hi_count_s);
      end
      rst_s = 1'b1; b_s = 1'b0; tick();
      checks++;
      if ({out_q_s, out_rise_s, hi_count_s} !== 4'b0 || out_s !== 1'b1) begin
         errors++;
         $display("FAIL saturate_reset: q=%b rise=%b cnt=%0d out=%b expected 0 0 0 1",
                  out_q_s, out_rise_s, hi_count_s, out_s);
      end
   endtask

   task automatic test_wide;
      rst_w = 1'b1; tick();
      rst_w = 1'b0; a_w = 8'hA0; b_w = 8'h05;
      #1;
      checks++;
      if (out_w !== 8'hA5 || out_q_w !== 8'h00) begin
         errors++;
         $display("FAIL wide_comb: out=%h out_q=%h expected a5 00", out_w, out_q_w);
      end
      @(posedge clk); #1;
      checks++;
      if (out_q_w !== 8'hA5) begin
         errors++;
         $display("FAIL wide_reg: out_q=%h expected a5", out_q_w);
      end
      tick();
      checks++;
      if (out_rise_w !== 1'b1 || hi_count_w !== 8'd1) begin
         errors++;
         $display("FAIL wide_rise: rise=%b cnt=%0d expected 1 1", out_rise_w, hi_count_w);
      end
   endtask

   task automatic test_back_to_back;
      exp_t e;
      drive(1'b0, 1'b0, 1'b1); tick(); void'(sb.pop_front());
      for (int i = 0; i < 40; i++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 15) == 0));
         #1;
         checks++;
         if (out !== (a | b)) begin
            errors++;
            $display("FAIL b2b_comb cyc%0d: out=%b expected %b", i, out, a | b);
         end
         @(posedge clk); #1;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL b2b_underflow cyc%0d: scoreboard empty", i);
         end else begin
            e = sb.pop_front();
            checks++;
            if ({out_q, out_rise, hi_count} !== {e.q, e.rise, e.cnt}) begin
               errors++;
               $display("FAIL b2b_reg cyc%0d: q=%b rise=%b cnt=%0d expected %b %b %0d",
                        i, out_q, out_rise, hi_count, e.q, e.rise, e.cnt);
            end
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_truth_table();
      @(posedge clk); #1;
      test_reset();
      test_registered();
      test_counter();
      test_mid_reset();
      test_saturation();
      test_wide();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
